// File: rtl/doodlejump_soc_key_input_pio.sv
// Push-button input PIO for the doodlejump SoC: per-key synchronizer and debouncer,
// W1C press-edge capture and a maskable level interrupt on a zero-wait Avalon-MM slave.
module doodlejump_soc_key_input_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam logic [15:0] CNT_MAX = 16'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2, stable;
  logic [WIDTH-1:0] edge_cap, irqmask;
  logic [WIDTH-1:0] upd, press, clr;
  logic [15:0]      cnt [WIDTH];
  logic             wr_en;
  logic             unused_wdata;

  // Bus semantics: no waitrequest, so every access completes in the cycle it is
  // presented; a write commits on the clk edge where chipselect && !write_n, and
  // readdata is a pure function of address and register state.
  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // A bit commits when its mismatch has persisted for DEBOUNCE_CYCLES samples.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    end
  end

  assign press = upd & ~sync2;
  assign clr   = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i] || upd[i]) cnt[i] <= '0;
        else                                 cnt[i] <= cnt[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable   <= '1;
      edge_cap <= '0;
      irqmask  <= '0;
    end else begin
      stable   <= (stable & ~upd) | (sync2 & upd);
      // A press landing on the same edge as a W1C clear wins.
      edge_cap <= (edge_cap & ~clr) | press;
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable;
      2'd2:    readdata[WIDTH-1:0] = irqmask;
      2'd3:    readdata[WIDTH-1:0] = edge_cap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irqmask);

endmodule

// File: tb/tb_doodlejump_soc_key_input_pio.sv
// Directed bench for the key input PIO (WIDTH=4, DEBOUNCE_CYCLES=4): vector table
// plus hand-timed sequences for set/clear collision and mid-count reset.
module tb_doodlejump_soc_key_input_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [3:0]  in_port = 4'hF;
  logic [31:0] readdata;
  logic        irq;

  int total = 0;
  int bad = 0;

  doodlejump_soc_key_input_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  in_val;
    logic        do_wr;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    int          wait_cyc;
    logic [1:0]  rd_addr;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [22];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    address    = a;
    chipselect = 1'b1;
    #1;
    check(name, readdata, exp);
    chipselect = 1'b0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  initial begin
    // in, wr, wr_addr, wr_data, wait, rd_addr, exp_rd, exp_irq
    vecs[0]  = '{4'hF, 1'b0, 2'd0, 32'h0,        1, 2'd0, 32'hF, 1'b0};
    vecs[1]  = '{4'hF, 1'b0, 2'd0, 32'h0,        0, 2'd2, 32'h0, 1'b0};
    vecs[2]  = '{4'hF, 1'b0, 2'd0, 32'h0,        0, 2'd3, 32'h0, 1'b0};
    vecs[3]  = '{4'hE, 1'b0, 2'd0, 32'h0,        3, 2'd0, 32'hF, 1'b0};  // glitch low 3 cycles
    vecs[4]  = '{4'hF, 1'b0, 2'd0, 32'h0,        6, 2'd0, 32'hF, 1'b0};
    vecs[5]  = '{4'hF, 1'b0, 2'd0, 32'h0,        0, 2'd3, 32'h0, 1'b0};
    vecs[6]  = '{4'hF, 1'b1, 2'd2, 32'h1,        0, 2'd2, 32'h1, 1'b0};
    vecs[7]  = '{4'hE, 1'b0, 2'd0, 32'h0,        5, 2'd0, 32'hF, 1'b0};  // one edge early
    vecs[8]  = '{4'hE, 1'b0, 2'd0, 32'h0,        1, 2'd0, 32'hE, 1'b1};  // N+1+4
    vecs[9]  = '{4'hE, 1'b0, 2'd0, 32'h0,        0, 2'd3, 32'h1, 1'b1};
    vecs[10] = '{4'hF, 1'b0, 2'd0, 32'h0,        5, 2'd0, 32'hE, 1'b1};
    vecs[11] = '{4'hF, 1'b0, 2'd0, 32'h0,        1, 2'd0, 32'hF, 1'b1};
    vecs[12] = '{4'hF, 1'b0, 2'd0, 32'h0,        0, 2'd3, 32'h1, 1'b1};  // release not cleared
    vecs[13] = '{4'hF, 1'b1, 2'd3, 32'h1,        0, 2'd3, 32'h0, 1'b0};
    vecs[14] = '{4'h3, 1'b1, 2'd2, 32'h0,        5, 2'd0, 32'h3, 1'b0};
    vecs[15] = '{4'h3, 1'b0, 2'd0, 32'h0,        0, 2'd3, 32'hC, 1'b0};
    vecs[16] = '{4'h3, 1'b1, 2'd2, 32'h8,        0, 2'd2, 32'h8, 1'b1};
    vecs[17] = '{4'h3, 1'b1, 2'd3, 32'h8,        0, 2'd3, 32'h4, 1'b0};
    vecs[18] = '{4'h3, 1'b1, 2'd1, 32'hFFFFFFFF, 0, 2'd1, 32'h0, 1'b0};
    vecs[19] = '{4'h3, 1'b1, 2'd0, 32'h0,        0, 2'd0, 32'h3, 1'b0};
    vecs[20] = '{4'h3, 1'b1, 2'd2, 32'hF,        0, 2'd2, 32'hF, 1'b1};
    vecs[21] = '{4'hF, 1'b1, 2'd2, 32'h0,        6, 2'd0, 32'hF, 1'b0};

    // clock/reset
    reset_n = 1'b0;
    cyc(2);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      in_port = vecs[i].in_val;
      if (vecs[i].do_wr) do_write(vecs[i].wr_addr, vecs[i].wr_data);
      cyc(vecs[i].wait_cyc);
      rd_check($sformatf("vec%0d_rd", i), vecs[i].rd_addr, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'b0, irq}, {31'b0, vecs[i].exp_irq});
    end

    // W1C of bit1 lands on the edge bit1's stable falls
    do_write(2'd3, 32'hF);
    do_write(2'd2, 32'h2);
    in_port = 4'hD;
    cyc(5);
    do_write(2'd3, 32'h2);
    rd_check("collide_edge", 2'd3, 32'h2);
    check("collide_irq", {31'b0, irq}, 32'h1);
    rd_check("collide_data", 2'd0, 32'hD);

    // async reset mid-count discards edges, mask and counts
    in_port = 4'hE;
    cyc(3);
    reset_n = 1'b0;
    #1;
    rd_check("rst_data", 2'd0, 32'hF);
    rd_check("rst_mask", 2'd2, 32'h0);
    rd_check("rst_edge", 2'd3, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(5);
    rd_check("post_rst_early", 2'd0, 32'hF);
    cyc(1);
    rd_check("post_rst_data", 2'd0, 32'hE);
    rd_check("post_rst_edge", 2'd3, 32'h1);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
